vga_grid_reader: RTL
====================

VGA_GRID_READER -- requirements
Module: vga_grid_reader

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- COLS_LOG2, 2, log2 of grid columns
- ROWS_LOG2, 2, log2 of grid rows
- CELL_W, 160, pixels per cell horizontally
- CELL_H, 120, lines per cell vertically
- BIT_DATO, 3, width of the colour data read back.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, reset, synchronous, active-high
- pix_en, in, 1, pixel-rate clock enable
- addr_r, out, COLS_LOG2+ROWS_LOG2, cell read address to the register bank
- dat_r, in, BIT_DATO, asynchronous read data for addr_r
- rgb, out, BIT_DATO, pixel colour
- hsync, out, 1, active-low horizontal sync
- vsync, out, 1, active-low vertical sync
- active, out, 1, rgb is a visible pixel
- frame_start, out, 1, one-cycle pulse at pixel (0,0).

Function
REQ-003 The block SHALL advance all counters and pipeline registers only on cycles with pix_en=1; with pix_en=0, all state SHALL hold.
REQ-004 The horizontal counter hc SHALL count 0..H_TOT-1, where H_TOT=H_VIS+H_FP+H_SYNC+H_BP, and then wrap to 0.
REQ-005 On each hc wrap, the vertical counter vc SHALL count 0..V_TOT-1, where V_TOT is defined the same way, and then wrap to 0.
REQ-006 Cell position SHALL be tracked with counters only (no divider):
- cx counts 0..CELL_W-1 and increments col on wrap; cx and col reset to 0 at hc=0.
- cy and row behave the same way on line wrap; they reset to 0 at vc=0.
REQ-007 addr_r SHALL equal {row, col}, i.e. row*2^COLS_LOG2+col.
REQ-008 col and row SHALL saturate at their maximum value if the visible area exceeds the grid.
REQ-009 Stage-0 sync SHALL be hs0=0 for hc in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] and vs0=0 for vc in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1]; otherwise 1.
REQ-010 Stage-0 active SHALL be act0 = (hc<H_VIS)&&(vc<V_VIS).
REQ-011 rgb, hsync, vsync, active and frame_start SHALL be registered one pix_en step after the addr_r they correspond to (latency 1), so that all outputs are mutually aligned.
REQ-012 rgb SHALL equal dat_r when act0=1, and SHALL be 0 during blanking.
REQ-013 frame_start SHALL be 1 for exactly one pix_en step per frame, aligned with output pixel (0,0).
REQ-014 A change in the bank contents SHALL appear on the next scan of that cell, with no frame buffering.

Reset
REQ-015 While rst=1, the block SHALL hold:
- hc, vc, cx, cy, col and row at 0
- addr_r=0, rgb=0, active=0, frame_start=0
- hsync=1, vsync=1.
REQ-016 Reset asserted mid-frame SHALL take priority over pix_en.
REQ-017 After rst is released, the first pix_en step SHALL scan pixel (0,0), and the next pix_en step SHALL output it with frame_start=1.

Configuration
REQ-018 With GRID_BORDER_EN defined, visible pixels with cx==0 or cy==0 SHALL output rgb = all ones (white grid lines).
REQ-019 Without GRID_BORDER_EN, rgb SHALL be dat_r for every visible pixel, and no border logic SHALL be synthesised.

Structure
REQ-020 A shared package SHALL hold the 640x480@60 timing defaults and the BIT_DATO default; these defaults SHALL be shared with the register bank.
REQ-021 hc/vc counting and stage-0 sync generation SHALL live in one sub-module, vga_timing.
REQ-022 Cell tracking, the address and the output pipeline SHALL live in the top level.

Verification
REQ-023 The bench SHALL use reduced parameters: H 8/1/2/1 (H_TOT=12), V 4/1/1/1 (V_TOT=7), CELL_W=2, CELL_H=1, COLS_LOG2=2, ROWS_LOG2=2, pix_en=1 continuously, with a 16-entry model bank whose cell k holds k mod 8. The scenarios are:
- V1: release rst -> frame_start=1 on the 2nd clock; the pixel at hc=5, vc=2 gives addr_r=10 and, one clock later, rgb=2 with active=1.
- V2: free run -> hsync low for exactly 2 clocks every 12; vsync low for exactly 12 clocks every 84; frame_start once per 84 clocks.
- V3: pix_en=1 every 3rd clock -> same waveforms as V2 stretched 3x; no output changes on enable-low cycles.
- V4: bank cell 5 changed from 5 to 7 mid-frame, before it is scanned -> the same frame shows rgb=7 at hc 2..3, vc 1.
- V5: rst pulsed for 1 clock at hc=7, vc=3 -> the next outputs are the reset values, then scanning restarts at (0,0) with frame_start.
- V6: GRID_BORDER_EN defined -> rgb=7 at every visible pixel with even hc; during blanking rgb=0 in both builds.

Source files
------------

// File: rtl/vga_grid_reader_pkg.sv
// Shared defaults for the grid reader and the register bank it reads from.
// 640x480@60 timing, colour width, and a counter-width helper.
package vga_grid_reader_pkg;

  localparam int H_VIS_DEF    = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_VIS_DEF    = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int BIT_DATO_DEF = 3;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster timing: hc/vc counters and stage-0 sync/active flags.
// line_end/frame_end tell the caller when the counters are about to wrap.
module vga_timing
  import vga_grid_reader_pkg::*;
#(
  parameter int H_VIS  = H_VIS_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_VIS  = V_VIS_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
  output logic hs0,
  output logic vs0,
  output logic act0,
  output logic origin,
  output logic line_end,
  output logic frame_end
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HC_W  = cnt_w(H_TOT);
  localparam int VC_W  = cnt_w(V_TOT);

  logic [HC_W-1:0] hc;
  logic [VC_W-1:0] vc;

  // Wrap detection for the horizontal and vertical counters
  always_comb begin
    line_end  = (hc == HC_W'(H_TOT - 1));
    frame_end = line_end && (vc == VC_W'(V_TOT - 1));
  end

  // Pixel and line counters, advancing on enabled cycles only
  always_ff @(posedge clk) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_en) begin
      if (line_end) begin
        hc <= '0;
        if (frame_end) vc <= '0;
        else           vc <= vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  // Stage-0 sync, active and frame-origin flags for the current position
  always_comb begin
    hs0    = !((int'(hc) >= H_VIS + H_FP) && (int'(hc) < H_VIS + H_FP + H_SYNC));
    vs0    = !((int'(vc) >= V_VIS + V_FP) && (int'(vc) < V_VIS + V_FP + V_SYNC));
    act0   = (int'(hc) < H_VIS) && (int'(vc) < V_VIS);
    origin = (hc == '0) && (vc == '0);
  end

endmodule

// File: rtl/vga_grid_reader.sv
// Scans a grid of colour cells onto a VGA raster. Cell position is tracked
// with counters, the cell address goes out combinationally and the bank's
// read data is registered together with sync/active (latency 1).
// Optional build macro GRID_BORDER_EN draws white lines at cell edges.
module vga_grid_reader
  import vga_grid_reader_pkg::*;
#(
  parameter int H_VIS     = H_VIS_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VIS     = V_VIS_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter int COLS_LOG2 = 2,
  parameter int ROWS_LOG2 = 2,
  parameter int CELL_W    = 160,
  parameter int CELL_H    = 120,
  parameter int BIT_DATO  = BIT_DATO_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pix_en,
  output logic [COLS_LOG2+ROWS_LOG2-1:0] addr_r,
  input  logic [BIT_DATO-1:0]            dat_r,
  output logic [BIT_DATO-1:0]            rgb,
  output logic                           hsync,
  output logic                           vsync,
  output logic                           active,
  output logic                           frame_start
);

  localparam int CX_W = cnt_w(CELL_W);
  localparam int CY_W = cnt_w(CELL_H);

  logic hs0, vs0, act0, origin, line_end, frame_end;
  logic [CX_W-1:0]      cx;
  logic [CY_W-1:0]      cy;
  logic [COLS_LOG2-1:0] col;
  logic [ROWS_LOG2-1:0] row;
  logic [BIT_DATO-1:0]  pix;

  vga_timing #(
    .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
    .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .pix_en    (pix_en),
    .hs0       (hs0),
    .vs0       (vs0),
    .act0      (act0),
    .origin    (origin),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  // Horizontal cell tracking; restarts with each line, column saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      cx  <= '0;
      col <= '0;
    end else if (pix_en) begin
      if (line_end) begin
        cx  <= '0;
        col <= '0;
      end else if (cx == CX_W'(CELL_W - 1)) begin
        cx <= '0;
        if (col != '1) col <= col + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

  // Vertical cell tracking on line wraps; restarts with each frame
  always_ff @(posedge clk) begin
    if (rst) begin
      cy  <= '0;
      row <= '0;
    end else if (pix_en && line_end) begin
      if (frame_end) begin
        cy  <= '0;
        row <= '0;
      end else if (cy == CY_W'(CELL_H - 1)) begin
        cy <= '0;
        if (row != '1) row <= row + 1'b1;
      end else begin
        cy <= cy + 1'b1;
      end
    end
  end

  // Cell address into the register bank
  always_comb begin
    addr_r = {row, col};
  end

  // Colour for the pixel currently addressed; black during blanking
  always_comb begin
    pix = '0;
    if (act0) begin
`ifdef GRID_BORDER_EN
      pix = ((cx == '0) || (cy == '0)) ? '1 : dat_r;
`else
      pix = dat_r;
`endif
    end
  end

  // Output stage: everything registered together so outputs stay aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb         <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      rgb         <= pix;
      hsync       <= hs0;
      vsync       <= vs0;
      active      <= act0;
      frame_start <= origin;
    end
  end

endmodule
